exec_sequencer: RTL and testbench

//  Multi-cycle controller that sequences the execute_unit datapath: fetches instructions over a req/ack port.

---
 rtl/exec_sequencer_pkg.sv | 26 ++
 rtl/exec_sequencer_pc_next_calc.sv | 29 ++
 rtl/exec_sequencer.sv | 162 ++++++++++++++++
 tb/tb_exec_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execute-unit sequencer: state codes, constants, helpers.
// No logic of its own; latency and backpressure are defined by the users.
// Imported by exec_sequencer and pc_next_calc.
package exec_sequencer_pkg;

  // FSM state codes; ST_BAD is never entered on purpose and recovers to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_BAD    = 3'd7
  } state_t;

  localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_INC         = 32'd4;

  // Word-aligned, sign-extended byte offset of a conditional branch.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/exec_sequencer_pc_next_calc.sv
// Next-PC generator: sequential, jump-target or branch-target address.
// Purely combinational, zero cycles.
// No handshake; the caller samples the result when it updates the PC.
module pc_next_calc
  import exec_sequencer_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_taken,
  input  logic        i_jump,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_instr_index,
  output logic [31:0] o_pc_next
);

  logic [31:0] w_p4;

  assign w_p4 = i_pc + PC_INC;

  // Jump wins over a taken branch; everything wraps modulo 2^32.
  always_comb begin
    o_pc_next = w_p4;
    if (i_jump) begin
      o_pc_next = {w_p4[31:28], i_instr_index, 2'b00};
    end else if (i_taken) begin
      o_pc_next = w_p4 + branch_offset(i_imm16);
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle controller: fetches over req/ack, holds IR, gates RF/DMEM writes, owns the PC.
// 4 cycles per instruction plus fetch wait; loads/stores add MEM_WAIT cycles in MEM.
// Fetch stalls in FETCH until imem_ack; no other backpressure, HALT is left only by reset.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_WAIT   = 1,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic [15:0]      dec_imm16,
  input  logic [25:0]      dec_instr_index,
  input  logic             alu_zero,
  output logic             reg_write_en,
  output logic             mem_write_en,
  output logic [31:0]      pc,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam int MW_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [MW_W-1:0] MEM_LAST = MW_W'(MEM_WAIT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_pc;
  logic [31:0]     r_instr;
  logic            r_taken;
  logic            r_jump;
  logic [MW_W-1:0] r_mem_cnt;
  logic [CNT_W-1:0] r_retired;
  logic            w_mem_last;
  logic            w_mem_op;
  logic [31:0]     w_pc_next;

  assign w_mem_op   = dec_mem_read | dec_mem_write;
  assign w_mem_last = (r_state == ST_MEM) && (r_mem_cnt == MEM_LAST);

  assign imem_addr = r_pc;
  assign instr     = r_instr;
  assign pc        = r_pc;
  assign state     = r_state;
  assign retired   = r_retired;

  pc_next_calc u_pc_next (
    .i_pc          (r_pc),
    .i_taken       (r_taken),
    .i_jump        (r_jump),
    .i_imm16       (dec_imm16),
    .i_instr_index (dec_instr_index),
    .o_pc_next     (w_pc_next)
  );

  // State register; reset forces IDLE from any state, which also drops imem_req at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs; enables are qualified by state so they cannot leak.
  always_comb begin
    w_state_nxt  = r_state;
    imem_req     = 1'b0;
    reg_write_en = 1'b0;
    mem_write_en = 1'b0;
    halted       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        w_state_nxt = (r_instr == HALT_INSTR) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        w_state_nxt = w_mem_op ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_write_en = w_mem_last & dec_mem_write;
        if (w_mem_last) w_state_nxt = ST_WB;
      end
      ST_WB: begin
        reg_write_en = dec_reg_write;
        w_state_nxt  = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Instruction register: loaded only on the accepted fetch, so it is stable DECODE..WB.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_instr <= 32'd0;
    end else if ((r_state == ST_FETCH) && imem_ack) begin
      r_instr <= imem_rdata;
    end
  end

  // Branch decision is captured in EXEC while alu_zero reflects this instruction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_taken <= 1'b0;
      r_jump  <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_taken <= dec_jump | (dec_branch & alu_zero);
      r_jump  <= dec_jump;
    end
  end

  // MEM dwell counter: cleared on the way in, counts up to MEM_WAIT-1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mem_cnt <= '0;
    end else if (r_state == ST_EXEC) begin
      r_mem_cnt <= '0;
    end else if ((r_state == ST_MEM) && !w_mem_last) begin
      r_mem_cnt <= r_mem_cnt + MW_W'(1);
    end
  end

  // PC advances once per instruction, in WB.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pc <= RESET_PC;
    end else if (r_state == ST_WB) begin
      r_pc <= w_pc_next;
    end
  end

  // Retired-instruction counter; wraps silently at all-ones.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_retired <= '0;
    end else if (r_state == ST_WB) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed table, random stream vs. reference model,
// and hand-written HALT / reset sequences. Two instances: A (MEM_WAIT=2, CNT_W=4),
// B (RESET_PC=0x1000_0000, MEM_WAIT=1), selected by 'sel'.
module tb_exec_sequencer;

  localparam int          MW_A  = 2;
  localparam int          CW_A  = 4;
  localparam logic [31:0] RPC_B = 32'h1000_0000;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] instr;
    logic        branch;
    logic        jump;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        zero;
    logic [15:0] imm;
    logic [25:0] idx;
    int          ack_delay;
    logic [31:0] exp_pc;
  } vec_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST_N;
  logic        sel;
  logic        start;
  logic        ack;
  logic [31:0] rdata;
  logic        d_branch, d_jump, d_rw, d_mr, d_mw, alu_zero;
  logic [15:0] d_imm;
  logic [25:0] d_idx;

  logic            a_req, b_req, a_rwe, b_rwe, a_mwe, b_mwe, a_halt, b_halt;
  logic [31:0]     a_addr, b_addr, a_instr, b_instr, a_pc, b_pc;
  logic [2:0]      a_state, b_state;
  logic [CW_A-1:0] a_ret;
  logic [31:0]     b_ret;

  logic        o_req, o_rwe, o_mwe, o_halt;
  logic [31:0] o_addr, o_instr, o_pc, o_ret;
  logic [2:0]  o_state;

  assign o_req   = sel ? b_req   : a_req;
  assign o_rwe   = sel ? b_rwe   : a_rwe;
  assign o_mwe   = sel ? b_mwe   : a_mwe;
  assign o_halt  = sel ? b_halt  : a_halt;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_instr = sel ? b_instr : a_instr;
  assign o_pc    = sel ? b_pc    : a_pc;
  assign o_state = sel ? b_state : a_state;
  assign o_ret   = sel ? b_ret   : {28'd0, a_ret};

  exec_sequencer #(.MEM_WAIT(MW_A), .CNT_W(CW_A)) u_a (
    .CLK(CLK), .RST_N(RST_N), .start(start & ~sel),
    .imem_req(a_req), .imem_addr(a_addr), .imem_ack(ack & ~sel), .imem_rdata(rdata),
    .instr(a_instr), .dec_branch(d_branch), .dec_jump(d_jump), .dec_reg_write(d_rw),
    .dec_mem_read(d_mr), .dec_mem_write(d_mw), .dec_imm16(d_imm), .dec_instr_index(d_idx),
    .alu_zero(alu_zero), .reg_write_en(a_rwe), .mem_write_en(a_mwe), .pc(a_pc),
    .state(a_state), .halted(a_halt), .retired(a_ret)
  );

  exec_sequencer #(.RESET_PC(RPC_B)) u_b (
    .CLK(CLK), .RST_N(RST_N), .start(start & sel),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ack(ack & sel), .imem_rdata(rdata),
    .instr(b_instr), .dec_branch(d_branch), .dec_jump(d_jump), .dec_reg_write(d_rw),
    .dec_mem_read(d_mr), .dec_mem_write(d_mw), .dec_imm16(d_imm), .dec_instr_index(d_idx),
    .alu_zero(alu_zero), .reg_write_en(b_rwe), .mem_write_en(b_mwe), .pc(b_pc),
    .state(b_state), .halted(b_halt), .retired(b_ret)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] cur_pc;
  logic [31:0] cur_ret;
  logic [31:0] ret_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic br, input logic jp,
                              input logic rw, input logic mr, input logic mw, input logic z,
                              input logic [15:0] imm, input logic [25:0] idx, input int dly,
                              input logic [31:0] epc);
    vec_t v;
    v.instr = instr; v.branch = br; v.jump = jp; v.rw = rw; v.mr = mr; v.mw = mw;
    v.zero = z; v.imm = imm; v.idx = idx; v.ack_delay = dly; v.exp_pc = epc;
    return v;
  endfunction

  // Reference next-PC from the architectural rules, plain arithmetic.
  function automatic logic [31:0] model_pc(input logic [31:0] p, input vec_t v);
    logic [31:0] p4;
    int          off;
    p4 = p + 32'd4;
    if (v.jump) return (p4 & 32'hF000_0000) | (32'(v.idx) * 32'd4);
    if (v.branch && v.zero) begin
      off = int'($signed(v.imm)) * 4;
      return p4 + 32'(off);
    end
    return p4;
  endfunction

  task automatic do_reset();
    start = 1'b0; ack = 1'b0; RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_req(output logic ok);
    int n;
    n = 0;
    while (!o_req && n < 40) begin
      @(negedge CLK);
      n++;
    end
    ok = o_req;
    if (!ok) check("fetch_req_timeout", 32'd0, 32'd1);
  endtask

  // Fetch one instruction, follow it to the next FETCH, check timing, enables, PC, retired.
  task automatic run_vec(input string tag, input vec_t v);
    int   n, mw, reg_cnt, mem_cnt, reg_idx, mem_idx, bad_rule, bad_ir, hold_bad, mcyc;
    logic ok;
    mw = sel ? 1 : MW_A;
    wait_req(ok);
    if (!ok) return;
    check({tag, "_imem_addr"}, o_addr, cur_pc);
    d_branch = v.branch; d_jump = v.jump; d_rw = v.rw; d_mr = v.mr; d_mw = v.mw;
    d_imm = v.imm; d_idx = v.idx; alu_zero = v.zero;
    hold_bad = 0;
    for (int i = 0; i < v.ack_delay; i++) begin
      rdata = $urandom;
      @(negedge CLK);
      if (!o_req || o_state != 3'd1) hold_bad++;
    end
    ack = 1'b1; rdata = v.instr;
    @(negedge CLK);
    ack = 1'b0; rdata = $urandom;
    n = 0; reg_cnt = 0; mem_cnt = 0; reg_idx = 0; mem_idx = 0; bad_rule = 0; bad_ir = 0;
    while (o_state != 3'd1 && o_state != 3'd6 && n < 20) begin
      n++;
      if (o_rwe) begin reg_cnt++; reg_idx = n; if (o_state != 3'd5) bad_rule++; end
      if (o_mwe) begin mem_cnt++; mem_idx = n; if (o_state != 3'd4) bad_rule++; end
      if (o_rwe && o_mwe) bad_rule++;
      if (o_instr !== v.instr) bad_ir++;
      start = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    start = 1'b0;
    mcyc = (v.mr || v.mw) ? mw : 0;
    cur_ret = (cur_ret + 32'd1) & ret_mask;
    check({tag, "_fetch_hold"}, 32'(hold_bad), 32'd0);
    check({tag, "_latency"}, 32'(n), 32'(3 + mcyc));
    check({tag, "_reg_we_pulses"}, 32'(reg_cnt), v.rw ? 32'd1 : 32'd0);
    check({tag, "_reg_we_cycle"}, 32'(reg_idx), v.rw ? 32'(3 + mcyc) : 32'd0);
    check({tag, "_mem_we_pulses"}, 32'(mem_cnt), v.mw ? 32'd1 : 32'd0);
    check({tag, "_mem_we_cycle"}, 32'(mem_idx), v.mw ? 32'(2 + mw) : 32'd0);
    check({tag, "_enable_rules"}, 32'(bad_rule), 32'd0);
    check({tag, "_instr_stable"}, 32'(bad_ir), 32'd0);
    check({tag, "_pc"}, o_pc, v.exp_pc);
    check({tag, "_retired"}, o_ret, cur_ret);
    cur_pc = v.exp_pc;
  endtask

  vec_t tbl[11];
  vec_t rv;
  int   bad;
  logic ok;

  initial begin
    sel = 1'b0; start = 1'b0; ack = 1'b0; rdata = 32'd0; RST_N = 1'b0;
    d_branch = 1'b0; d_jump = 1'b0; d_rw = 1'b0; d_mr = 1'b0; d_mw = 1'b0;
    alu_zero = 1'b0; d_imm = 16'd0; d_idx = 26'd0;

    //        instr          br    jp    rw    mr    mw    z     imm       idx          dly exp_pc
    tbl[0]  = mk(32'h2001_0005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 26'h0,       3, 32'h0000_0004);
    tbl[1]  = mk(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0,       0, 32'h0000_0008);
    tbl[2]  = mk(32'hAC01_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 26'h0,       1, 32'h0000_000C);
    tbl[3]  = mk(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h0,       2, 32'h0000_0010);
    tbl[4]  = mk(32'h1000_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFC, 26'h0,       0, 32'h0000_0004);
    tbl[5]  = mk(32'h0800_0004, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 26'h4,       1, 32'h0000_0010);
    tbl[6]  = mk(32'h1000_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFC, 26'h0,       0, 32'h0000_0014);
    tbl[7]  = mk(32'h1000_FFF9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFF9, 26'h0,       0, 32'hFFFF_FFFC);
    tbl[8]  = mk(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0,       1, 32'h0000_0000);
    tbl[9]  = mk(32'h8C01_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 26'h0,       0, 32'h0000_0004);
    tbl[10] = mk(32'h1000_0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 26'h20,      2, 32'h0000_0080);

    // ---- instance A: reset state ----
    ret_mask = 32'h0000_000F;
    do_reset();
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_pc", o_pc, 32'd0);
    check("rst_instr", o_instr, 32'd0);
    check("rst_retired", o_ret, 32'd0);
    check("rst_outputs", {28'd0, o_req, o_rwe, o_mwe, o_halt}, 32'd0);

    // IDLE ignores ack and waits for start.
    ack = 1'b1; rdata = 32'h1234_5678;
    repeat (3) @(negedge CLK);
    ack = 1'b0;
    check("idle_wait_state", 32'(o_state), 32'd0);
    check("idle_wait_instr", o_instr, 32'd0);

    // ---- directed table ----
    cur_pc = 32'd0; cur_ret = 32'd0;
    pulse_start();
    for (int i = 0; i < 11; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // ---- randomized stream against the reference model (crosses the retired wrap) ----
    for (int i = 0; i < 24; i++) begin
      rv.instr  = $urandom;
      if (rv.instr == HALT) rv.instr = 32'd0;
      rv.branch = 1'($urandom_range(0, 1));
      rv.jump   = ($urandom_range(0, 3) == 0);
      rv.rw     = 1'($urandom_range(0, 1));
      rv.mr     = ($urandom_range(0, 2) == 0);
      rv.mw     = ($urandom_range(0, 2) == 0);
      rv.zero   = 1'($urandom_range(0, 1));
      rv.imm    = 16'($urandom);
      rv.idx    = 26'($urandom);
      rv.ack_delay = $urandom_range(0, 3);
      rv.exp_pc = model_pc(cur_pc, rv);
      run_vec($sformatf("rnd%0d", i), rv);
    end

    // ---- HALT: sticky, ignores start/ack ----
    wait_req(ok);
    if (ok) begin
      d_rw = 1'b1; d_mw = 1'b1; d_mr = 1'b1;
      ack = 1'b1; rdata = HALT;
      @(negedge CLK);
      ack = 1'b0;
      @(negedge CLK);
      check("halt_state", 32'(o_state), 32'd6);
      check("halt_flag", 32'(o_halt), 32'd1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        start = 1'($urandom_range(0, 1));
        ack   = 1'($urandom_range(0, 1));
        rdata = $urandom;
        @(negedge CLK);
        if (o_state != 3'd6 || !o_halt || o_req || o_rwe || o_mwe) bad++;
      end
      start = 1'b0; ack = 1'b0;
      check("halt_sticky", 32'(bad), 32'd0);
      check("halt_pc_frozen", o_pc, cur_pc);
      check("halt_retired_frozen", o_ret, cur_ret);
      @(posedge CLK);
      #2 RST_N = 1'b0;
      #1;
      check("halt_async_rst_state", 32'(o_state), 32'd0);
      check("halt_async_rst_pc", o_pc, 32'd0);
      check("halt_async_rst_flag", 32'(o_halt), 32'd0);
      check("halt_async_rst_retired", o_ret, 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
    end

    // ---- reset mid-fetch: req drops at once, late ack ignored ----
    @(negedge CLK);
    pulse_start();
    check("midfetch_req_up", 32'(o_req), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    check("midfetch_req_drop", 32'(o_req), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge CLK);
    ack = 1'b0;
    check("late_ack_state", 32'(o_state), 32'd0);
    check("late_ack_instr", o_instr, 32'd0);

    // ---- instance B: RESET_PC and MEM_WAIT=1 ----
    sel = 1'b1;
    ret_mask = 32'hFFFF_FFFF;
    do_reset();
    check("b_rst_pc", o_pc, RPC_B);
    cur_pc = RPC_B; cur_ret = 32'd0;
    pulse_start();
    run_vec("b_jump", mk(32'h0800_0040, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040,
                         26'h0000040, 1, 32'h1000_0100));
    run_vec("b_sw", mk(32'hAC02_0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0004,
                       26'h0, 0, 32'h1000_0104));
    run_vec("b_lw", mk(32'h8C02_0004, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0004,
                       26'h0, 2, 32'h1000_0108));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
